// File: rtl/sdram_arb_if.sv
// Requester/pin bundle of the SDRAM command arbiter. The slave side is the
// arbiter itself; the master side is the init/refresh/write/read logic plus the pad.
interface sdram_arb_if #(parameter int DATA_W = 16);
  logic              init_end;
  logic [3:0]        init_cmd;
  logic [1:0]        init_bank;
  logic [12:0]       init_addr;
  logic              ar_req, ar_end;
  logic [3:0]        ar_cmd;
  logic [1:0]        ar_bank;
  logic [12:0]       ar_addr;
  logic              wr_req, wr_end;
  logic [3:0]        wr_cmd;
  logic [1:0]        wr_bank;
  logic [12:0]       wr_addr;
  logic              wr_sdram_en;
  logic [DATA_W-1:0] wr_sdram_data;
  logic              rd_req, rd_end;
  logic [3:0]        rd_cmd;
  logic [1:0]        rd_bank;
  logic [12:0]       rd_addr;
  logic              ar_en, wr_en, rd_en;
  logic              sdram_cke;
  logic              sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [1:0]        sdram_ba;
  logic [12:0]       sdram_addr;
  logic [DATA_W-1:0] sdram_dq_out;
  logic              sdram_dq_oe;
  logic              err_timeout;

  modport slave (
    input  init_end, init_cmd, init_bank, init_addr,
    input  ar_req, ar_end, ar_cmd, ar_bank, ar_addr,
    input  wr_req, wr_end, wr_cmd, wr_bank, wr_addr, wr_sdram_en, wr_sdram_data,
    input  rd_req, rd_end, rd_cmd, rd_bank, rd_addr,
    output ar_en, wr_en, rd_en, sdram_cke,
    output sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
    output sdram_ba, sdram_addr, sdram_dq_out, sdram_dq_oe, err_timeout
  );

  modport master (
    output init_end, init_cmd, init_bank, init_addr,
    output ar_req, ar_end, ar_cmd, ar_bank, ar_addr,
    output wr_req, wr_end, wr_cmd, wr_bank, wr_addr, wr_sdram_en, wr_sdram_data,
    output rd_req, rd_end, rd_cmd, rd_bank, rd_addr,
    input  ar_en, wr_en, rd_en, sdram_cke,
    input  sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
    input  sdram_ba, sdram_addr, sdram_dq_out, sdram_dq_oe, err_timeout
  );
endinterface

// File: rtl/sdram_arb.sv
// SDRAM command-bus arbiter: init ownership, then refresh > write/read
// (round-robin), with a grant watchdog. Pins decode the state with no added latency.
module sdram_arb #(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 1023
) (
  input logic       arb_clk,
  input logic       arb_rst,
  sdram_arb_if.slave bus
);
  typedef enum logic [2:0] {S_INIT, S_IDLE, S_AREF, S_WRITE, S_READ} state_t;

  localparam logic [9:0] WD_LAST = 10'(TIMEOUT - 1);

  state_t            r_state;
  logic              r_last_rd;
  logic [9:0]        r_wdog;
  logic              r_err;
  logic              w_end;
  logic [3:0]        w_cmd;
  logic [DATA_W-1:0] w_dq;

  // Only the granted requester's end pulse counts.
  assign w_end = (r_state == S_AREF  && bus.ar_end) ||
                 (r_state == S_WRITE && bus.wr_end) ||
                 (r_state == S_READ  && bus.rd_end);

  always_ff @(posedge arb_clk) begin
    if (arb_rst) begin
      r_state   <= S_INIT;
      r_last_rd <= 1'b1;
      r_wdog    <= '0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        S_INIT: if (bus.init_end) r_state <= S_IDLE;
        S_IDLE: begin
          r_wdog <= '0;
          if (bus.ar_req) r_state <= S_AREF;
          else if (bus.wr_req && (!bus.rd_req || r_last_rd)) begin
            r_state   <= S_WRITE;
            r_last_rd <= 1'b0;
          end else if (bus.rd_req) begin
            r_state   <= S_READ;
            r_last_rd <= 1'b1;
          end
        end
        S_AREF, S_WRITE, S_READ: begin
          // End beats the watchdog when both land on the same edge.
          if (w_end) r_state <= S_IDLE;
          else if (r_wdog == WD_LAST) begin
            r_state <= S_IDLE;
            r_err   <= 1'b1;
          end else r_wdog <= r_wdog + 10'd1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_cmd          = 4'b0111;
    bus.sdram_ba   = 2'b11;
    bus.sdram_addr = 13'h1fff;
    case (r_state)
      S_INIT:  begin w_cmd = bus.init_cmd; bus.sdram_ba = bus.init_bank; bus.sdram_addr = bus.init_addr; end
      S_AREF:  begin w_cmd = bus.ar_cmd;   bus.sdram_ba = bus.ar_bank;   bus.sdram_addr = bus.ar_addr;   end
      S_WRITE: begin w_cmd = bus.wr_cmd;   bus.sdram_ba = bus.wr_bank;   bus.sdram_addr = bus.wr_addr;   end
      S_READ:  begin w_cmd = bus.rd_cmd;   bus.sdram_ba = bus.rd_bank;   bus.sdram_addr = bus.rd_addr;   end
      default: ;
    endcase
  end

  assign w_dq = bus.wr_sdram_data;

  assign {bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n} = w_cmd;
  assign bus.ar_en        = (r_state == S_AREF);
  assign bus.wr_en        = (r_state == S_WRITE);
  assign bus.rd_en        = (r_state == S_READ);
  assign bus.sdram_cke    = 1'b1;
  assign bus.sdram_dq_oe  = bus.wr_sdram_en && (r_state == S_WRITE);
  assign bus.sdram_dq_out = w_dq;
  assign bus.err_timeout  = r_err;
endmodule

// File: tb/tb_sdram_arb.sv
// Bench for sdram_arb: vector table, directed corner sequences and random
// traffic checked every cycle against an ownership-based reference model.
module tb_sdram_arb;
  localparam int TIMEOUT = 1023;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sdram_arb_if #(.DATA_W(16)) b ();
  sdram_arb #(.DATA_W(16), .TIMEOUT(TIMEOUT)) dut (.arb_clk(clk), .arb_rst(rst), .bus(b));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: who owns the bus and for how long.
  bit m_valid = 0, m_init_done = 0, m_last_wr = 0, m_err = 0;
  int m_owner = 0;  // 0 none, 1 refresh, 2 write, 3 read
  int m_held  = 0;

  typedef struct {
    logic [8:0] inp;  // {rst, init_end, ar_req, ar_end, wr_req, wr_end, rd_req, rd_end, wr_sdram_en}
    logic [7:0] exp;  // {ar_en, wr_en, rd_en, cmd[3:0], dq_oe}
  } vec_t;
  vec_t vec[17];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [40:0] act_vec();
    return {b.ar_en, b.wr_en, b.rd_en, b.sdram_cke, b.sdram_cs_n, b.sdram_ras_n,
            b.sdram_cas_n, b.sdram_we_n, b.sdram_ba, b.sdram_addr, b.sdram_dq_oe,
            b.sdram_dq_out, b.err_timeout};
  endfunction

  function automatic logic [40:0] exp_vec();
    logic [3:0] c; logic [1:0] ba; logic [12:0] ad;
    c = 4'b0111; ba = 2'b11; ad = 13'h1fff;
    if (!m_init_done) begin c = b.init_cmd; ba = b.init_bank; ad = b.init_addr; end
    else if (m_owner == 1) begin c = b.ar_cmd; ba = b.ar_bank; ad = b.ar_addr; end
    else if (m_owner == 2) begin c = b.wr_cmd; ba = b.wr_bank; ad = b.wr_addr; end
    else if (m_owner == 3) begin c = b.rd_cmd; ba = b.rd_bank; ad = b.rd_addr; end
    return {m_owner == 1, m_owner == 2, m_owner == 3, 1'b1, c, ba, ad,
            (m_owner == 2) && b.wr_sdram_en, b.wr_sdram_data, m_err};
  endfunction

  task automatic model_edge();
    bit fin;
    fin = (m_owner == 1 && b.ar_end) || (m_owner == 2 && b.wr_end) || (m_owner == 3 && b.rd_end);
    if (rst) begin
      m_valid = 1; m_init_done = 0; m_owner = 0; m_last_wr = 0; m_err = 0; m_held = 0;
    end else if (!m_init_done) m_init_done = b.init_end;
    else if (m_owner == 0) begin
      if (b.ar_req) m_owner = 1;
      else if (b.wr_req && b.rd_req) m_owner = m_last_wr ? 3 : 2;
      else if (b.wr_req) m_owner = 2;
      else if (b.rd_req) m_owner = 3;
      if (m_owner == 2) m_last_wr = 1;
      if (m_owner == 3) m_last_wr = 0;
      m_held = 1;
    end else if (fin) m_owner = 0;
    else if (m_held == TIMEOUT) begin m_owner = 0; m_err = 1; end
    else m_held++;
  endtask

  // Check the settled outputs, then advance one clock edge.
  task automatic cycle();
    #1;
    if (m_valid) chk("model", 64'(act_vec()), 64'(exp_vec()));
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clr_ctl();
    b.ar_req = 0; b.ar_end = 0; b.wr_req = 0; b.wr_end = 0;
    b.rd_req = 0; b.rd_end = 0; b.wr_sdram_en = 0;
  endtask

  task automatic reset_init();
    clr_ctl(); rst = 1; b.init_end = 0;
    cycle(); cycle();
    rst = 0; b.init_end = 1;
    cycle();
  endtask

  // Wait (bounded) for any grant, hold it, then pulse that requester's end.
  task automatic serve(output int who);
    who = 0;
    for (int i = 0; i < 20 && who == 0; i++) begin
      cycle();
      if (b.ar_en) who = 1; else if (b.wr_en) who = 2; else if (b.rd_en) who = 3;
    end
    if (who == 1) b.ar_req = 0;
    repeat (7) cycle();
    if (who == 1) b.ar_end = 1; else if (who == 2) b.wr_end = 1; else if (who == 3) b.rd_end = 1;
    cycle();
    b.ar_end = 0; b.wr_end = 0; b.rd_end = 0;
    chk("idle_gap", 64'({b.ar_en, b.wr_en, b.rd_en}), 64'(0));
  endtask

  initial begin
    int who, cnt;
    int rr_exp[5] = '{2, 3, 1, 2, 3};
    clr_ctl();
    b.init_end = 0;
    b.init_cmd = 4'b0010; b.init_bank = 2'b01; b.init_addr = 13'h0400;
    b.ar_cmd = 4'b0001; b.ar_bank = 2'b00; b.ar_addr = 13'h0011;
    b.wr_cmd = 4'b0100; b.wr_bank = 2'b10; b.wr_addr = 13'h0a5a;
    b.rd_cmd = 4'b0101; b.rd_bank = 2'b01; b.rd_addr = 13'h15a5;
    b.wr_sdram_data = 16'hbeef;

    vec[0]  = '{9'b1_0_0_0_0_0_0_0_0, 8'b000_0010_0};
    vec[1]  = '{9'b0_0_0_0_0_0_0_0_0, 8'b000_0010_0};
    vec[2]  = '{9'b0_1_1_0_1_0_1_0_0, 8'b000_0010_0};
    vec[3]  = '{9'b0_1_1_0_1_0_1_0_0, 8'b000_0111_0};
    vec[4]  = '{9'b0_1_1_0_1_0_1_0_1, 8'b100_0001_0};
    vec[5]  = '{9'b0_1_0_1_1_0_1_0_1, 8'b100_0001_0};
    vec[6]  = '{9'b0_1_0_0_1_0_1_0_0, 8'b000_0111_0};
    vec[7]  = '{9'b0_1_0_0_0_0_1_0_1, 8'b010_0100_1};
    vec[8]  = '{9'b0_1_0_0_0_0_1_1_1, 8'b010_0100_1};
    vec[9]  = '{9'b0_1_0_0_0_1_1_0_0, 8'b010_0100_0};
    vec[10] = '{9'b0_1_0_0_0_0_1_0_0, 8'b000_0111_0};
    vec[11] = '{9'b0_1_0_0_0_0_0_0_1, 8'b001_0101_0};
    vec[12] = '{9'b0_1_0_0_0_0_0_1_0, 8'b001_0101_0};
    vec[13] = '{9'b0_0_0_0_0_0_0_0_0, 8'b000_0111_0};
    vec[14] = '{9'b0_0_0_0_1_0_0_0_0, 8'b000_0111_0};
    vec[15] = '{9'b1_0_0_0_0_0_0_0_0, 8'b010_0100_0};
    vec[16] = '{9'b0_0_0_0_0_0_0_0_0, 8'b000_0010_0};

    // Vector table
    rst = 1;
    cycle();
    for (int i = 0; i < 17; i++) begin
      {rst, b.init_end, b.ar_req, b.ar_end, b.wr_req, b.wr_end, b.rd_req, b.rd_end, b.wr_sdram_en} = vec[i].inp;
      #1;
      chk($sformatf("vec%0d", i),
          64'({b.ar_en, b.wr_en, b.rd_en, b.sdram_cs_n, b.sdram_ras_n, b.sdram_cas_n, b.sdram_we_n, b.sdram_dq_oe}),
          64'(vec[i].exp));
      cycle();
    end

    // Power-up: init owns the pins until init_end
    clr_ctl(); rst = 1; b.init_end = 0;
    cycle(); cycle();
    rst = 0;
    repeat (18) cycle();
    chk("pwrup_init_cmd", 64'({b.sdram_cs_n, b.sdram_ras_n, b.sdram_cas_n, b.sdram_we_n}), 64'(4'b0010));
    chk("pwrup_no_en", 64'({b.ar_en, b.wr_en, b.rd_en, b.sdram_dq_oe, b.err_timeout}), 64'(0));
    b.init_end = 1;
    cycle();
    chk("pwrup_nop", 64'({b.sdram_cs_n, b.sdram_ras_n, b.sdram_cas_n, b.sdram_we_n, b.sdram_ba, b.sdram_addr}),
        64'({4'b0111, 2'b11, 13'h1fff}));

    // Round-robin with an interleaved refresh
    reset_init();
    b.wr_req = 1; b.rd_req = 1;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) b.ar_req = 1;
      serve(who);
      chk($sformatf("rr_grant%0d", k), 64'(who), 64'(rr_exp[k]));
    end
    clr_ctl();
    cycle();

    // No preemption of a running write
    reset_init();
    b.wr_req = 1;
    cycle();
    b.wr_req = 0;
    repeat (3) cycle();
    b.ar_req = 1;
    repeat (4) cycle();
    chk("nopre_held", 64'({b.ar_en, b.wr_en}), 64'(2'b01));
    b.wr_end = 1;
    cycle();
    b.wr_end = 0;
    chk("nopre_gap", 64'({b.ar_en, b.wr_en}), 64'(2'b00));
    cycle();
    chk("nopre_aref", 64'(b.ar_en), 64'(1));
    b.ar_req = 0; b.ar_end = 1;
    cycle();
    b.ar_end = 0;
    cycle();

    // Watchdog: read never ends
    reset_init();
    b.rd_req = 1;
    cycle();
    b.rd_req = 0;
    cnt = 0;
    for (int i = 0; i < 1100 && b.rd_en; i++) begin cnt++; cycle(); end
    chk("wd_len", 64'(cnt), 64'(TIMEOUT));
    chk("wd_err", 64'(b.err_timeout), 64'(1));
    b.wr_req = 1;
    serve(who);
    b.wr_req = 0;
    chk("wd_wr_served", 64'(who), 64'(2));
    chk("wd_sticky", 64'(b.err_timeout), 64'(1));
    rst = 1;
    cycle();
    rst = 0;
    chk("wd_cleared", 64'(b.err_timeout), 64'(0));

    // Random traffic against the model
    reset_init();
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom % 500) == 0;
      b.init_end   = ($urandom % 16) != 0;
      b.ar_req     = ($urandom % 8) == 0;
      b.ar_end     = ($urandom % 6) == 0;
      b.wr_req     = ($urandom % 3) == 0;
      b.wr_end     = ($urandom % 6) == 0;
      b.rd_req     = ($urandom % 3) == 0;
      b.rd_end     = ($urandom % 6) == 0;
      b.wr_sdram_en = 1'($urandom);
      b.wr_sdram_data = 16'($urandom);
      b.init_cmd = 4'($urandom); b.init_bank = 2'($urandom); b.init_addr = 13'($urandom);
      b.ar_cmd   = 4'($urandom); b.ar_bank   = 2'($urandom); b.ar_addr   = 13'($urandom);
      b.wr_cmd   = 4'($urandom); b.wr_bank   = 2'($urandom); b.wr_addr   = 13'($urandom);
      b.rd_cmd   = 4'($urandom); b.rd_bank   = 2'($urandom); b.rd_addr   = 13'($urandom);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
